// File: rtl/instr_decoder_pipe_if.sv
// Handshake bundle between the instruction source, the pipelined decoder
// and the downstream issue stage.
interface instr_decoder_pipe_if #(
    parameter int unsigned OP_W    = 4,
    parameter int unsigned REG_W   = 2,
    parameter int unsigned INSTR_W = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instruction;
    logic               out_valid;
    logic               out_ready;
    logic [OP_W-1:0]    out_op_code;
    logic [REG_W-1:0]   destination_register;
    logic [REG_W-1:0]   source_register;
    logic               out_illegal;
    logic               out_raw_hazard;

    modport master (
        output in_valid, in_instruction, out_ready,
        input  in_ready, out_valid, out_op_code, destination_register,
               source_register, out_illegal, out_raw_hazard
    );

    modport slave (
        input  in_valid, in_instruction, out_ready,
        output in_ready, out_valid, out_op_code, destination_register,
               source_register, out_illegal, out_raw_hazard
    );
endinterface

// File: rtl/instr_decoder_pipe.sv
// Pipelined instruction decoder: splits op/dst/src, flags illegal opcodes and
// RAW hazards against the previous accept, and queues results in a small FIFO.
module instr_decoder_pipe #(
    parameter int unsigned OP_W       = 4,
    parameter int unsigned REG_W      = 2,
    parameter int unsigned INSTR_W    = 8,
    parameter int unsigned NUM_OPS    = 12,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    instr_decoder_pipe_if.slave         bus,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]            decode_count
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);
    localparam logic [31:0]      NUM_OPS_U = 32'(NUM_OPS);

    if (INSTR_W != OP_W + 2 * REG_W) begin : g_bad_instr_w
        $error("instr_decoder_pipe: INSTR_W must equal OP_W + 2*REG_W");
    end
    if (NUM_OPS > (1 << OP_W)) begin : g_bad_num_ops
        $error("instr_decoder_pipe: NUM_OPS exceeds opcode space");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("instr_decoder_pipe: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] dst;
        logic [REG_W-1:0] src;
        logic             illegal;
        logic             hazard;
    } entry_t;

    entry_t             mem_q [FIFO_DEPTH];
    entry_t             hold_q, hold_d;
    entry_t             new_entry, head;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [REG_W-1:0]   last_dst_q, last_dst_d;
    logic               last_vld_q, last_vld_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               not_empty, push, pop;

    assign not_empty    = (level_q != '0);
    assign bus.in_ready = (level_q != FULL_LVL) & ~flush;
    assign push         = bus.in_valid & bus.in_ready;
    assign pop          = not_empty & bus.out_ready & ~flush;

    always_comb begin
        new_entry.op      = bus.in_instruction[INSTR_W-1 -: OP_W];
        new_entry.dst     = bus.in_instruction[2*REG_W-1 -: REG_W];
        new_entry.src     = bus.in_instruction[REG_W-1:0];
        new_entry.illegal = (32'(new_entry.op) >= NUM_OPS_U);
        new_entry.hazard  = last_vld_q & (new_entry.src == last_dst_q);
    end

    // Once the FIFO drains, outputs keep showing the last head seen.
    assign head = not_empty ? mem_q[rd_ptr_q] : hold_q;

    assign bus.out_valid            = not_empty;
    assign bus.out_op_code          = head.op;
    assign bus.destination_register = head.dst;
    assign bus.source_register      = head.src;
    assign bus.out_illegal          = head.illegal;
    assign bus.out_raw_hazard       = head.hazard;
    assign fifo_level               = level_q;
    assign decode_count             = cnt_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        last_dst_d = last_dst_q;
        last_vld_d = last_vld_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        if (not_empty) begin
            hold_d = mem_q[rd_ptr_q];
        end
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            last_vld_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                last_dst_d = new_entry.dst;
                last_vld_d = 1'b1;
                cnt_d      = cnt_q + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                level_d = level_q + LVL_W'(1);
            end else if (pop && !push) begin
                level_d = level_q - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            last_dst_q <= '0;
            last_vld_q <= 1'b0;
            cnt_q      <= '0;
            hold_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            last_dst_q <= last_dst_d;
            last_vld_q <= last_vld_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
        end
    end

    // Storage is only read while level_q != 0, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end
endmodule

// File: tb/tb_instr_decoder_pipe.sv
// Directed self-checking bench for instr_decoder_pipe.
module tb_instr_decoder_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [2:0]  fifo_level, fifo_level_w;
    logic [15:0] decode_count;
    logic [3:0]  decode_count_w;
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  vec [6];

    always #5 clk = ~clk;

    instr_decoder_pipe_if #(.OP_W(4), .REG_W(2), .INSTR_W(8)) bus ();
    instr_decoder_pipe_if #(.OP_W(4), .REG_W(2), .INSTR_W(8)) bus_w ();

    instr_decoder_pipe #(
        .OP_W(4), .REG_W(2), .INSTR_W(8), .NUM_OPS(12), .FIFO_DEPTH(4), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus),
        .fifo_level(fifo_level), .decode_count(decode_count)
    );

    instr_decoder_pipe #(
        .OP_W(4), .REG_W(2), .INSTR_W(8), .NUM_OPS(12), .FIFO_DEPTH(4), .CNT_W(4)
    ) dut_w (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus_w),
        .fifo_level(fifo_level_w), .decode_count(decode_count_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] head_fields();
        return {bus.out_op_code, bus.destination_register, bus.source_register};
    endfunction

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_instruction = '0;
        bus.out_ready = 1'b0;
        bus_w.in_valid = 1'b0;
        bus_w.in_instruction = '0;
        bus_w.out_ready = 1'b1;
        vec[0] = 8'h01; vec[1] = 8'h12; vec[2] = 8'h23;
        vec[3] = 8'h34; vec[4] = 8'h45; vec[5] = 8'h56;

        tick();
        tick();
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst level", fifo_level, 0);
        chk("rst count", decode_count, 0);
        chk("rst fields", head_fields(), 0);
        chk("rst illegal", bus.out_illegal, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("post-rst in_ready", bus.in_ready, 1);

        // 1: single decode, latency 1
        bus.in_valid = 1'b1;
        bus.in_instruction = 8'h5B;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("t1 out_valid", bus.out_valid, 1);
        chk("t1 op", bus.out_op_code, 5);
        chk("t1 dst", bus.destination_register, 2);
        chk("t1 src", bus.source_register, 3);
        chk("t1 illegal", bus.out_illegal, 0);
        chk("t1 hazard", bus.out_raw_hazard, 0);
        chk("t1 count", decode_count, 1);

        // 2: hazard chain and illegal opcode, streaming with pops
        bus.in_valid = 1'b1;
        bus.in_instruction = 8'h24;
        tick();
        chk("t2 24 fields", head_fields(), 8'h24);
        chk("t2 24 hazard", bus.out_raw_hazard, 0);
        chk("t2 level", fifo_level, 1);
        bus.in_instruction = 8'h31;
        tick();
        chk("t2 31 fields", head_fields(), 8'h31);
        chk("t2 31 hazard", bus.out_raw_hazard, 1);
        bus.in_instruction = 8'hC0;
        tick();
        chk("t2 C0 op", bus.out_op_code, 12);
        chk("t2 C0 illegal", bus.out_illegal, 1);
        chk("t2 C0 hazard", bus.out_raw_hazard, 1);
        chk("t2 count", decode_count, 4);
        bus.in_valid = 1'b0;
        tick();
        chk("t2 empty valid", bus.out_valid, 0);
        chk("t2 empty level", fifo_level, 0);
        chk("t2 hold op", bus.out_op_code, 12);
        chk("t2 hold illegal", bus.out_illegal, 1);

        // 3: fill to full with consumer stalled, then drain in order
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instruction = vec[i];
            chk("t3 in_ready", bus.in_ready, (i < 4) ? 1 : 0);
            tick();
            chk("t3 level", fifo_level, (i < 4) ? i + 1 : 4);
        end
        bus.in_valid = 1'b0;
        chk("t3 count", decode_count, 8);
        bus.out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("t3 drain valid", bus.out_valid, 1);
            chk("t3 drain fields", head_fields(), vec[j]);
            chk("t3 drain hazard", bus.out_raw_hazard, (j == 3) ? 1 : 0);
            tick();
        end
        chk("t3 drained valid", bus.out_valid, 0);
        chk("t3 drained level", fifo_level, 0);

        // 4: simultaneous push/pop at level 2, then flush
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_instruction = 8'h67;
        tick();
        bus.in_instruction = 8'h78;
        tick();
        chk("t4 level2", fifo_level, 2);
        chk("t4 head A", head_fields(), 8'h67);
        bus.out_ready = 1'b1;
        bus.in_instruction = 8'h89;
        tick();
        chk("t4 push+pop level", fifo_level, 2);
        chk("t4 push+pop head", head_fields(), 8'h78);
        flush = 1'b1;
        bus.in_instruction = 8'h9A;
        #1;
        chk("t4 flush in_ready", bus.in_ready, 0);
        tick();
        flush = 1'b0;
        chk("t4 flush level", fifo_level, 0);
        chk("t4 flush valid", bus.out_valid, 0);
        chk("t4 flush count", decode_count, 11);
        bus.out_ready = 1'b0;
        bus.in_instruction = 8'hA6;
        tick();
        chk("t4 post-flush head", head_fields(), 8'hA6);
        chk("t4 post-flush hazard", bus.out_raw_hazard, 0);
        chk("t4 post-flush level", fifo_level, 1);
        chk("t4 post-flush count", decode_count, 12);

        // 5: async reset mid-stream
        bus.in_instruction = 8'h0F;
        tick();
        bus.in_instruction = 8'h1D;
        tick();
        bus.in_valid = 1'b0;
        chk("t5 level3", fifo_level, 3);
        #3;
        rst = 1'b0;
        #1;
        chk("t5 async valid", bus.out_valid, 0);
        chk("t5 async level", fifo_level, 0);
        chk("t5 async count", decode_count, 0);
        chk("t5 async fields", head_fields(), 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("t5 in_ready", bus.in_ready, 1);

        // 5b: counter wrap on the narrow-counter instance
        bus_w.in_valid = 1'b1;
        bus_w.in_instruction = 8'h11;
        for (int k = 0; k < 15; k++) begin
            tick();
        end
        bus_w.in_valid = 1'b0;
        chk("t5 count max", decode_count_w, 4'hF);
        bus_w.in_valid = 1'b1;
        tick();
        bus_w.in_valid = 1'b0;
        chk("t5 count wrap", decode_count_w, 0);
        chk("t5 wrap head", bus_w.out_valid, 1);
        chk("t5 main count idle", decode_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
